axilite_m: RTL and testbench

AXILITE_M -- requirements
Module: axilite_m

---
 rtl/axilite_pkg.sv | 20 ++
 rtl/axilite_m.sv | 136 +++++++++++++
 tb/tb_axilite_m.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_pkg.sv
// Shared types and constants for the AXI-Lite single-transaction master.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axilite_m.sv
// AXI-Lite master: turns one command at a time into an AXI-Lite read or write
// and returns the completion on a response handshake.
module axilite_m
  import axilite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,

  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  state_t state;

  // AW and W each count as done once their valid has dropped or is handshaking now
  logic aw_done;
  logic w_done;

  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  // Readies and rsp_valid are pure decodes of the state register
  assign cmd_ready = (state == IDLE);
  assign bready    = (state == WR_RESP);
  assign rready    = (state == RD_DATA);
  assign rsp_valid = (state == RSP);

  assign awprot = AXI_PROT_DEFAULT;
  assign arprot = AXI_PROT_DEFAULT;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= IDLE;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_we) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done)  state   <= WR_RESP;
        end

        WR_RESP: begin
          if (bvalid) begin
            rsp_resp  <= bresp;
            rsp_we    <= 1'b1;
            rsp_rdata <= '0;
            state     <= RSP;
          end
        end

        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_we    <= 1'b0;
            state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_m.sv
// Directed and randomised bench for axilite_m against a small AXI-Lite slave model.
module tb_axilite_m;

  logic        axi_aclk;
  logic        axi_aresetn;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  axilite_m #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // ---------------- slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] next_resp = 2'b00;
  logic stray_b = 1'b0, stray_r = 1'b0;

  logic [31:0] mem [16];
  int aw_wait, w_wait, ar_wait, b_cnt, r_cnt, b_consumed;
  logic aw_got, w_got, b_pend, r_pend, bvalid_q, rvalid_q;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q, rdata_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q, rresp_q;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid && (ar_wait >= ar_delay);
  assign bvalid  = bvalid_q | stray_b;
  assign rvalid  = rvalid_q | stray_r;
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  always @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
      b_consumed <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; ar_addr_q <= '0; rdata_q <= '0;
      w_strb_q <= '0; bresp_q <= '0; rresp_q <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid  && !wready)  ? w_wait + 1  : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; end
      if (aw_got && w_got && !b_pend && !bvalid_q) begin
        for (int i = 0; i < 4; i++)
          if (w_strb_q[i]) mem[aw_addr_q[5:2]][i*8 +: 8] <= w_data_q[i*8 +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
      end
      if (b_pend) begin
        if (b_cnt >= b_delay) begin bvalid_q <= 1'b1; bresp_q <= next_resp; b_pend <= 1'b0; end
        else b_cnt <= b_cnt + 1;
      end
      if (bvalid_q && bready) begin bvalid_q <= 1'b0; b_consumed <= b_consumed + 1; end
      if (arvalid && arready) begin r_pend <= 1'b1; r_cnt <= 0; ar_addr_q <= araddr; end
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          rvalid_q <= 1'b1; rdata_q <= mem[ar_addr_q[5:2]]; rresp_q <= next_resp; r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (rvalid_q && rready) rvalid_q <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int rsp_cnt = 0;
  always @(posedge axi_aclk)
    if (axi_aresetn && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;

  // A valid seen waiting must still be high with the same payload one cycle later
  logic aw_pend_p = 1'b0, w_pend_p = 1'b0, ar_pend_p = 1'b0;
  logic [31:0] awaddr_p, wdata_p, araddr_p;
  logic [3:0]  wstrb_p;
  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      aw_pend_p <= 1'b0; w_pend_p <= 1'b0; ar_pend_p <= 1'b0;
    end else begin
      if (aw_pend_p) check("aw_hold", {awvalid, awaddr}, {1'b1, awaddr_p});
      if (w_pend_p)  check("w_hold", {wvalid, wstrb, wdata}, {1'b1, wstrb_p, wdata_p});
      if (ar_pend_p) check("ar_hold", {arvalid, araddr}, {1'b1, araddr_p});
      aw_pend_p <= awvalid && !awready; awaddr_p <= awaddr;
      w_pend_p  <= wvalid && !wready;   wdata_p <= wdata; wstrb_p <= wstrb;
      ar_pend_p <= arvalid && !arready; araddr_p <= araddr;
    end
  end

  // ---------------- reference and drivers ----------------
  logic [31:0] ref_mem [16];

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int n = 0;
    cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge axi_aclk); n++; end
    check("cmd_accept_bound", 64'(n < 50), 64'd1);
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    if (we) check("wr_issue_latency", {awvalid, wvalid}, 2'b11);
    else    check("rd_issue_latency", arvalid, 1'b1);
  endtask

  task automatic get_rsp(input int hold, output logic we, output logic [31:0] rd,
                         output logic [1:0] resp);
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge axi_aclk); n++; end
    check("rsp_bound", 64'(n < 200), 64'd1);
    we = rsp_we; rd = rsp_rdata; resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge axi_aclk);
      check("rsp_payload_hold", {rsp_valid, rsp_we, rsp_resp, rsp_rdata}, {1'b1, we, resp, rd});
      check("rsp_hold_quiet", {cmd_ready, awvalid, wvalid, arvalid}, 4'b0000);
    end
    rsp_ready = 1'b1;
    @(negedge axi_aclk);
    rsp_ready = 1'b0;
    check("rsp_release", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int hold, input logic [1:0] exp_resp);
    logic g_we; logic [31:0] g_rd; logic [1:0] g_resp;
    send_cmd(we, addr, data, strb);
    get_rsp(hold, g_we, g_rd, g_resp);
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[addr[5:2]][i*8 +: 8] = data[i*8 +: 8];
      check("wr_rsp", {g_we, g_resp, g_rd}, {1'b1, exp_resp, 32'h0});
    end else begin
      check("rd_rsp", {g_we, g_resp, g_rd}, {1'b0, exp_resp, ref_mem[addr[5:2]]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, r0, waits, n;
    logic g_we; logic [31:0] g_rd; logic [1:0] g_resp;
    axi_aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    ref_reset();
    repeat (3) @(negedge axi_aclk);
    check("reset_handshakes", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    check("reset_payload", {awaddr, araddr}, 64'h0);
    check("reset_wdata", {wstrb, wdata, awprot, arprot}, 64'h0);
    check("reset_rsp", {rsp_we, rsp_resp, rsp_rdata}, 64'h0);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    check("idle_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write then readback
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 2'b00);

    // W completes three cycles ahead of AW
    aw_delay = 3; w_delay = 0;
    b0 = b_consumed; r0 = rsp_cnt;
    send_cmd(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(negedge axi_aclk);
    check("w_first_split", {awvalid, wvalid}, 2'b10);
    get_rsp(0, g_we, g_rd, g_resp);
    ref_mem[8] = 32'h1234_5678;
    check("w_first_rsp", {g_we, g_resp}, 3'b100);
    repeat (3) @(negedge axi_aclk);
    check("w_first_one_b", 64'(b_consumed - b0), 64'd1);
    check("w_first_one_rsp", 64'(rsp_cnt - r0), 64'd1);

    // AW completes ahead of W, partial strobe
    aw_delay = 0; w_delay = 3;
    send_cmd(1'b1, 32'h24, 32'hAABB_CCDD, 4'b0011);
    @(negedge axi_aclk);
    check("aw_first_split", {awvalid, wvalid}, 2'b01);
    get_rsp(0, g_we, g_rd, g_resp);
    ref_mem[9][15:0] = 16'hCCDD;
    check("aw_first_rsp", {g_we, g_resp}, 3'b100);
    w_delay = 0;
    do_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 2'b00);

    // Delayed AR with SLVERR on R
    ar_delay = 5; next_resp = 2'b10;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    waits = 0; n = 0;
    while (arvalid && n < 50) begin
      if (!arready) waits++;
      check("ar_addr", araddr, 32'h4);
      @(negedge axi_aclk); n++;
    end
    check("ar_wait_cycles", 64'(waits), 64'd5);
    get_rsp(0, g_we, g_rd, g_resp);
    check("rd_slverr", {g_we, g_resp, g_rd}, {1'b0, 2'b10, ref_mem[1]});
    ar_delay = 0;

    // DECERR on a write passes through unchanged
    next_resp = 2'b11;
    do_txn(1'b1, 32'h30, 32'h0102_0304, 4'b0101, 0, 2'b11);
    next_resp = 2'b00;

    // Consumer stalls the response for ten cycles
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 10, 2'b00);

    // Stray B/R while idle must be ignored
    stray_b = 1'b1; stray_r = 1'b1;
    repeat (3) begin
      @(negedge axi_aclk);
      check("stray_ignored", {rsp_valid, cmd_ready, bready, rready}, 4'b0100);
    end
    stray_b = 1'b0; stray_r = 1'b0;
    @(negedge axi_aclk);

    // Reset while waiting for B
    b_delay = 30;
    send_cmd(1'b1, 32'h8, 32'h5555_AAAA, 4'hF);
    n = 0;
    while (!bready && n < 20) begin @(negedge axi_aclk); n++; end
    check("reach_wr_resp", bready, 1'b1);
    axi_aresetn = 1'b0;
    #1;
    check("mid_reset_handshakes", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    @(negedge axi_aclk);
    check("mid_reset_hold", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    axi_aresetn = 1'b1;
    ref_reset();
    b_delay = 0;
    repeat (10) begin
      @(negedge axi_aclk);
      check("post_reset_idle", {rsp_valid, cmd_ready, awvalid, wvalid, arvalid}, 5'b01000);
    end

    // Randomised traffic against the scoreboard
    for (int t = 0; t < 300; t++) begin
      logic        r_we;
      logic [31:0] r_addr, r_data;
      logic [3:0]  r_strb;
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      next_resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 15)) << 2;
      r_data = $urandom;
      r_strb = 4'($urandom_range(0, 15));
      do_txn(r_we, r_addr, r_data, r_strb, $urandom_range(0, 2), next_resp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
